// File: rtl/jam_param_if.sv
// Host-side bus of the job-assignment solver. It carries the start handshake,
// the cost-table query port and the result outputs. clk and rst stay outside it.
interface jam_param_if #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) ();
  logic              Start;
  logic              Mode;
  logic [2:0]        W;
  logic [2:0]        J;
  logic              Query;
  logic [COST_W-1:0] Cost;
  logic              Busy;
  logic              Valid;
  logic [SUM_W-1:0]  BestCost;
  logic [CNT_W-1:0]  MatchCount;
  logic [3*N-1:0]    BestPerm;

  // Host / cost-ROM side: starts runs, answers queries, reads results.
  modport master (
    output Start, Mode, Cost,
    input  W, J, Query, Busy, Valid, BestCost, MatchCount, BestPerm
  );

  // Solver side.
  modport slave (
    input  Start, Mode, Cost,
    output W, J, Query, Busy, Valid, BestCost, MatchCount, BestPerm
  );
endinterface

// File: rtl/jam_param.sv
// Exhaustive N x N job-assignment solver. It walks all N! permutations in
// lexicographic order and queries one (worker, job) cost per cycle. It keeps
// the best total (min or max), how many permutations reach it, and the first
// permutation that reached it.
module jam_param #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic       CLK,
  input  logic       RST,
  jam_param_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EVAL = 3'd1,
    CMP  = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0] K_LAST = 3'(N - 1);

  state_t            state_reg, state_next;
  logic [2:0]        perm_reg [N];
  logic [2:0]        perm_next [N];
  logic [2:0]        k_reg, k_next;
  logic [SUM_W-1:0]  acc_reg, acc_next;
  logic              mode_reg, mode_next;
  logic              first_reg, first_next;
  logic [SUM_W-1:0]  best_reg, best_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [3*N-1:0]    bperm_reg, bperm_next;
  logic [SUM_W-1:0]  best_cost_reg, best_cost_next;
  logic [CNT_W-1:0]  match_count_reg, match_count_next;
  logic [3*N-1:0]    best_perm_reg, best_perm_next;

  logic [COST_W-1:0] cost_in;
  logic [2:0]        w_sel;
  logic [3*N-1:0]    perm_flat;
  logic [N-1:0]      desc_match;
  logic              is_last;
  logic              better;

  // Successor datapath signals.
  logic [2:0]        pivot, swap_idx;
  logic [2:0]        piv_val, swap_val;
  logic [2:0]        swapped [N];
  logic [2:0]        succ [N];

  assign cost_in = bus.Cost;

  // Packed view of the permutation and the "descending = last" detector.
  for (genvar gi = 0; gi < N; gi++) begin : g_perm
    localparam logic [2:0] DESC_VAL = 3'(N - 1 - gi);
    assign perm_flat[3*gi +: 3] = perm_reg[gi];
    assign desc_match[gi]       = (perm_reg[gi] == DESC_VAL);
  end
  assign is_last = &desc_match;

  // Worker currently assigned to job k; mux over constant indices.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (3'(i) == k_reg) w_sel = perm_reg[i];
    end
  end

  // Next-permutation search: rightmost ascent and rightmost larger element.
  // Only consumed when the current permutation is not the last one, so an
  // ascent is guaranteed to exist whenever the result is used.
  always_comb begin
    pivot = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_reg[i] < perm_reg[i+1]) pivot = 3'(i);
    end
    piv_val = '0;
    for (int i = 0; i < N; i++) begin
      if (3'(i) == pivot) piv_val = perm_reg[i];
    end
    swap_idx = '0;
    for (int i = 0; i < N; i++) begin
      if ((3'(i) > pivot) && (perm_reg[i] > piv_val)) swap_idx = 3'(i);
    end
    swap_val = '0;
    for (int i = 0; i < N; i++) begin
      if (3'(i) == swap_idx) swap_val = perm_reg[i];
    end
  end

  // Swap pivot with its successor element, then mirror the suffix after the
  // pivot; position p > pivot takes element N + pivot - p.
  for (genvar gi = 0; gi < N; gi++) begin : g_succ
    logic [3:0] mirror_idx;
    logic [2:0] mirror_val;

    assign swapped[gi] = (pivot == 3'(gi))    ? swap_val :
                         (swap_idx == 3'(gi)) ? piv_val  : perm_reg[gi];

    assign mirror_idx = 4'(N) + {1'b0, pivot} - 4'(gi);

    // Pick the mirrored source element for this position.
    always_comb begin
      mirror_val = '0;
      for (int q = 0; q < N; q++) begin
        if (4'(q) == mirror_idx) mirror_val = swapped[q];
      end
    end

    assign succ[gi] = (3'(gi) > pivot) ? mirror_val : swapped[gi];
  end

  assign better = mode_reg ? (acc_reg > best_reg) : (acc_reg < best_reg);

  // Next-state and datapath control for the whole run.
  always_comb begin
    state_next       = state_reg;
    k_next           = k_reg;
    acc_next         = acc_reg;
    mode_next        = mode_reg;
    first_next       = first_reg;
    best_next        = best_reg;
    count_next       = count_reg;
    bperm_next       = bperm_reg;
    best_cost_next   = best_cost_reg;
    match_count_next = match_count_reg;
    best_perm_next   = best_perm_reg;
    for (int i = 0; i < N; i++) perm_next[i] = perm_reg[i];

    case (state_reg)
      IDLE: begin
        if (bus.Start) begin
          mode_next  = bus.Mode;
          acc_next   = '0;
          k_next     = '0;
          first_next = 1'b1;
          for (int i = 0; i < N; i++) perm_next[i] = 3'(i);
          state_next = EVAL;
        end
      end

      EVAL: begin
        acc_next = acc_reg + SUM_W'(cost_in);
        if (k_reg == K_LAST) begin
          k_next     = '0;
          state_next = CMP;
        end else begin
          k_next = k_reg + 3'd1;
        end
      end

      CMP: begin
        first_next = 1'b0;
        if (first_reg || better) begin
          best_next  = acc_reg;
          count_next = CNT_W'(1);
          bperm_next = perm_flat;
        end else if (acc_reg == best_reg) begin
          count_next = count_reg + CNT_W'(1);
        end
        if (is_last) begin
          // Results become visible together with the Valid pulse in DONE.
          best_cost_next   = best_next;
          match_count_next = count_next;
          best_perm_next   = bperm_next;
          state_next       = DONE;
        end else begin
          state_next = NEXT;
        end
      end

      NEXT: begin
        for (int i = 0; i < N; i++) perm_next[i] = succ[i];
        acc_next   = '0;
        k_next     = '0;
        state_next = EVAL;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to idle/identity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= IDLE;
      k_reg           <= '0;
      acc_reg         <= '0;
      mode_reg        <= 1'b0;
      first_reg       <= 1'b1;
      best_reg        <= '0;
      count_reg       <= '0;
      bperm_reg       <= '0;
      best_cost_reg   <= '0;
      match_count_reg <= '0;
      best_perm_reg   <= '0;
      for (int i = 0; i < N; i++) perm_reg[i] <= 3'(i);
    end else begin
      state_reg       <= state_next;
      k_reg           <= k_next;
      acc_reg         <= acc_next;
      mode_reg        <= mode_next;
      first_reg       <= first_next;
      best_reg        <= best_next;
      count_reg       <= count_next;
      bperm_reg       <= bperm_next;
      best_cost_reg   <= best_cost_next;
      match_count_reg <= match_count_next;
      best_perm_reg   <= best_perm_next;
      for (int i = 0; i < N; i++) perm_reg[i] <= perm_next[i];
    end
  end

  assign bus.Query      = (state_reg == EVAL);
  assign bus.W          = (state_reg == EVAL) ? w_sel : 3'd0;
  assign bus.J          = (state_reg == EVAL) ? k_reg : 3'd0;
  assign bus.Busy       = (state_reg == EVAL) || (state_reg == CMP) || (state_reg == NEXT);
  assign bus.Valid      = (state_reg == DONE);
  assign bus.BestCost   = best_cost_reg;
  assign bus.MatchCount = match_count_reg;
  assign bus.BestPerm   = best_perm_reg;

endmodule

// File: tb/tb_jam_param.sv
// Directed bench for jam_param: N=2/3/4 small tables in sequence, and an
// N=8 all-127 run in parallel. Each N has its own solver instance.
module tb_jam_param;

  localparam int LAT8   = 40320 * 20 + 2;
  localparam int LIM_SM = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst3, rst4, rst8;
  logic start_s, mode_s, start8;
  int   sel;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic done8;

  jam_param_if #(.N(2)) if2 ();
  jam_param_if #(.N(3)) if3 ();
  jam_param_if #(.N(4)) if4 ();
  jam_param_if #(.N(8)) if8 ();

  jam_param #(.N(2)) u_n2 (.CLK(clk), .RST(rst2), .bus(if2));
  jam_param #(.N(3)) u_n3 (.CLK(clk), .RST(rst3), .bus(if3));
  jam_param #(.N(4)) u_n4 (.CLK(clk), .RST(rst4), .bus(if4));
  jam_param #(.N(8)) u_n8 (.CLK(clk), .RST(rst8), .bus(if8));

  // Cost tables
  assign if2.Start = start_s && (sel == 0);
  assign if3.Start = start_s && (sel == 1);
  assign if4.Start = start_s && (sel == 2);
  assign if2.Mode  = mode_s;
  assign if3.Mode  = mode_s;
  assign if4.Mode  = mode_s;
  assign if2.Cost  = (if2.W == if2.J) ? 7'd1  : 7'd3;
  assign if3.Cost  = (if3.W == if3.J) ? 7'd10 : 7'd1;
  assign if4.Cost  = (if4.W == if4.J) ? 7'd10 : 7'd1;
  assign if8.Start = start8;
  assign if8.Mode  = 1'b0;
  assign if8.Cost  = 7'd127;

  // View of the currently selected small instance
  logic        m_valid, m_busy, m_query;
  logic [31:0] m_w, m_j, m_cost, m_cnt, m_perm;
  always_comb begin
    m_valid = if4.Valid;  m_busy = if4.Busy;  m_query = if4.Query;
    m_w     = 32'(if4.W); m_j = 32'(if4.J);
    m_cost  = 32'(if4.BestCost); m_cnt = 32'(if4.MatchCount); m_perm = 32'(if4.BestPerm);
    case (sel)
      0: begin
        m_valid = if2.Valid;  m_busy = if2.Busy;  m_query = if2.Query;
        m_w     = 32'(if2.W); m_j = 32'(if2.J);
        m_cost  = 32'(if2.BestCost); m_cnt = 32'(if2.MatchCount); m_perm = 32'(if2.BestPerm);
      end
      1: begin
        m_valid = if3.Valid;  m_busy = if3.Busy;  m_query = if3.Query;
        m_w     = 32'(if3.W); m_j = 32'(if3.J);
        m_cost  = 32'(if3.BestCost); m_cnt = 32'(if3.MatchCount); m_perm = 32'(if3.BestPerm);
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic launch(input int s, input logic m);
    sel = s;
    @(negedge clk);
    start_s = 1'b1;
    mode_s  = m;
    @(negedge clk);
    start_s = 1'b0;
    check_eq($sformatf("launch%0d busy", s), m_busy, 1'b1);
  endtask

  // Wait for Valid; optionally pulse Start with Mode=1 mid-run at cycle glitch_at.
  task automatic wait_valid(input string tag, input int glitch_at);
    int cyc = 0;
    while (!m_valid && cyc < LIM_SM) begin
      @(negedge clk);
      cyc++;
      if (cyc == glitch_at) begin
        start_s = 1'b1;
        mode_s  = 1'b1;
      end else if (cyc == glitch_at + 1) begin
        start_s = 1'b0;
        mode_s  = 1'b0;
      end
    end
    check_eq({tag, " valid"}, m_valid, 1'b1);
  endtask

  task automatic check_res(input string tag, input logic [31:0] ecost,
                           input logic [31:0] ecnt, input logic [31:0] eperm);
    check_eq({tag, " BestCost"},   m_cost, ecost);
    check_eq({tag, " MatchCount"}, m_cnt,  ecnt);
    check_eq({tag, " BestPerm"},   m_perm, eperm);
    check_eq({tag, " busy low"},   m_busy, 1'b0);
  endtask

  initial begin
    rst2 = 1'b1; rst3 = 1'b1; rst4 = 1'b1; rst8 = 1'b1;
    start_s = 1'b0; mode_s = 1'b0; start8 = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    check_eq("rst W",          m_w,     0);
    check_eq("rst J",          m_j,     0);
    check_eq("rst Query",      m_query, 0);
    check_eq("rst Busy",       m_busy,  0);
    check_eq("rst Valid",      m_valid, 0);
    check_eq("rst BestCost",   m_cost,  0);
    check_eq("rst MatchCount", m_cnt,   0);
    check_eq("rst BestPerm",   m_perm,  0);
    rst2 = 1'b0; rst3 = 1'b0; rst4 = 1'b0; rst8 = 1'b0;
    @(negedge clk);

    // N=2 minimise, then Start held across DONE relaunches a maximise run
    launch(0, 1'b0);
    wait_valid("n2 min", 0);
    check_res("n2 min", 2, 1, 32'h08);
    start_s = 1'b1;
    mode_s  = 1'b1;
    @(negedge clk);
    check_eq("n2 idle after done busy", m_busy,  1'b0);
    check_eq("n2 valid dropped",        m_valid, 1'b0);
    @(negedge clk);
    start_s = 1'b0;
    check_eq("n2 relaunch busy",  m_busy, 1'b1);
    check_eq("n2 results held",   m_cost, 2);
    wait_valid("n2 max", 0);
    check_res("n2 max", 6, 1, 32'h01);
    @(negedge clk);
    check_eq("n2 valid one cycle", m_valid, 1'b0);

    // N=3
    launch(1, 1'b0);
    wait_valid("n3 min", 0);
    check_res("n3 min", 3, 2, 32'h011);
    launch(1, 1'b1);
    wait_valid("n3 max", 0);
    check_res("n3 max", 30, 1, 32'h088);

    // N=4 clean run, mid-EVAL reset, rerun with Start pulsed while busy
    launch(2, 1'b0);
    wait_valid("n4 clean", 0);
    check_res("n4 clean", 4, 9, 32'h4C1);
    launch(2, 1'b0);
    @(negedge clk);
    check_eq("n4 mid query", m_query, 1'b1);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check_eq("n4 rst W",          m_w,     0);
    check_eq("n4 rst J",          m_j,     0);
    check_eq("n4 rst Query",      m_query, 0);
    check_eq("n4 rst Busy",       m_busy,  0);
    check_eq("n4 rst Valid",      m_valid, 0);
    check_eq("n4 rst BestCost",   m_cost,  0);
    check_eq("n4 rst MatchCount", m_cnt,   0);
    check_eq("n4 rst BestPerm",   m_perm,  0);
    launch(2, 1'b0);
    wait_valid("n4 rerun", 3);
    check_res("n4 rerun", 4, 9, 32'h4C1);

    begin
      int guard = 0;
      while (!done8 && guard < LAT8 + 100) begin
        @(negedge clk);
        guard++;
      end
      check_eq("n8 thread finished", done8, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // N=8, every cost 127: every permutation ties
  initial begin
    int cyc;
    int q8;
    int v8;
    done8 = 1'b0;
    q8    = 0;
    repeat (5) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (cyc <= LAT8) begin
      if (if8.Query) q8++;
      if (if8.Valid) break;
      @(negedge clk);
      cyc++;
    end
    check_eq("n8 valid",          if8.Valid, 1'b1);
    check_eq("n8 latency bound",  (cyc <= LAT8), 1'b1);
    check_eq("n8 BestCost",       64'(if8.BestCost),   1016);
    check_eq("n8 MatchCount",     64'(if8.MatchCount), 40320);
    check_eq("n8 BestPerm",       64'(if8.BestPerm),   64'hFAC688);
    check_eq("n8 query count",    q8, 322560);
    v8 = if8.Valid ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (if8.Valid) v8++;
    end
    check_eq("n8 valid pulses",   v8, 1);
    done8 = 1'b1;
  end

endmodule
